// File: rtl/camellia_pkg.sv
// Shared Camellia constants: key-schedule SIGMAs, the s1 substitution table,
// s2/s3/s4 derivations and the KA generator state type.
package camellia_pkg;

  localparam logic [63:0] SIGMA1 = 64'hA09E667F3BCC908B;
  localparam logic [63:0] SIGMA2 = 64'hB67AE8584CAA73B2;
  localparam logic [63:0] SIGMA3 = 64'hC6EF372FE94F82BE;
  localparam logic [63:0] SIGMA4 = 64'h54FF53A5F1D36F1C;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ka_state_e;

  localparam logic [7:0] SBOX1 [256] = '{
    8'h70, 8'h82, 8'h2c, 8'hec, 8'hb3, 8'h27, 8'hc0, 8'he5, 8'he4, 8'h85, 8'h57, 8'h35, 8'hea, 8'h0c, 8'hae, 8'h41,
    8'h23, 8'hef, 8'h6b, 8'h93, 8'h45, 8'h19, 8'ha5, 8'h21, 8'hed, 8'h0e, 8'h4f, 8'h4e, 8'h1d, 8'h65, 8'h92, 8'hbd,
    8'h86, 8'hb8, 8'haf, 8'h8f, 8'h7c, 8'heb, 8'h1f, 8'hce, 8'h3e, 8'h30, 8'hdc, 8'h5f, 8'h5e, 8'hc5, 8'h0b, 8'h1a,
    8'ha6, 8'he1, 8'h39, 8'hca, 8'hd5, 8'h47, 8'h5d, 8'h3d, 8'hd9, 8'h01, 8'h5a, 8'hd6, 8'h51, 8'h56, 8'h6c, 8'h4d,
    8'h8b, 8'h0d, 8'h9a, 8'h66, 8'hfb, 8'hcc, 8'hb0, 8'h2d, 8'h74, 8'h12, 8'h2b, 8'h20, 8'hf0, 8'hb1, 8'h84, 8'h99,
    8'hdf, 8'h4c, 8'hcb, 8'hc2, 8'h34, 8'h7e, 8'h76, 8'h05, 8'h6d, 8'hb7, 8'ha9, 8'h31, 8'hd1, 8'h17, 8'h04, 8'hd7,
    8'h14, 8'h58, 8'h3a, 8'h61, 8'hde, 8'h1b, 8'h11, 8'h1c, 8'h32, 8'h0f, 8'h9c, 8'h16, 8'h53, 8'h18, 8'hf2, 8'h22,
    8'hfe, 8'h44, 8'hcf, 8'hb2, 8'hc3, 8'hb5, 8'h7a, 8'h91, 8'h24, 8'h08, 8'he8, 8'ha8, 8'h60, 8'hfc, 8'h69, 8'h50,
    8'haa, 8'hd0, 8'ha0, 8'h7d, 8'ha1, 8'h89, 8'h62, 8'h97, 8'h54, 8'h5b, 8'h1e, 8'h95, 8'he0, 8'hff, 8'h64, 8'hd2,
    8'h10, 8'hc4, 8'h00, 8'h48, 8'ha3, 8'hf7, 8'h75, 8'hdb, 8'h8a, 8'h03, 8'he6, 8'hda, 8'h09, 8'h3f, 8'hdd, 8'h94,
    8'h87, 8'h5c, 8'h83, 8'h02, 8'hcd, 8'h4a, 8'h90, 8'h33, 8'h73, 8'h67, 8'hf6, 8'hf3, 8'h9d, 8'h7f, 8'hbf, 8'he2,
    8'h52, 8'h9b, 8'hd8, 8'h26, 8'hc8, 8'h37, 8'hc6, 8'h3b, 8'h81, 8'h96, 8'h6f, 8'h4b, 8'h13, 8'hbe, 8'h63, 8'h2e,
    8'he9, 8'h79, 8'ha7, 8'h8c, 8'h9f, 8'h6e, 8'hbc, 8'h8e, 8'h29, 8'hf5, 8'hf9, 8'hb6, 8'h2f, 8'hfd, 8'hb4, 8'h59,
    8'h78, 8'h98, 8'h06, 8'h6a, 8'he7, 8'h46, 8'h71, 8'hba, 8'hd4, 8'h25, 8'hab, 8'h42, 8'h88, 8'ha2, 8'h8d, 8'hfa,
    8'h72, 8'h07, 8'hb9, 8'h55, 8'hf8, 8'hee, 8'hac, 8'h0a, 8'h36, 8'h49, 8'h2a, 8'h68, 8'h3c, 8'h38, 8'hf1, 8'ha4,
    8'h40, 8'h28, 8'hd3, 8'h7b, 8'hbb, 8'hc9, 8'h43, 8'hc1, 8'h15, 8'he3, 8'had, 8'hf4, 8'h77, 8'hc7, 8'h80, 8'h9e
  };

  function automatic logic [7:0] sbox1(input logic [7:0] b);
    return SBOX1[b];
  endfunction

  function automatic logic [7:0] sbox2(input logic [7:0] b);
    logic [7:0] s;
    s = SBOX1[b];
    return {s[6:0], s[7]};
  endfunction

  function automatic logic [7:0] sbox3(input logic [7:0] b);
    logic [7:0] s;
    s = SBOX1[b];
    return {s[0], s[7:1]};
  endfunction

  function automatic logic [7:0] sbox4(input logic [7:0] b);
    return SBOX1[{b[6:0], b[7]}];
  endfunction

endpackage

// File: rtl/camellia_f.sv
// Combinational Camellia F-function: key XOR, S-box layer, P byte-mixing network.
module camellia_f (
  input  logic [63:0] x,
  input  logic [63:0] k,
  output logic [63:0] y
);
  import camellia_pkg::*;

  logic [63:0] xk;
  logic [7:0]  t1, t2, t3, t4, t5, t6, t7, t8;

  always_comb begin
    xk = x ^ k;
    t1 = sbox1(xk[63:56]);
    t2 = sbox2(xk[55:48]);
    t3 = sbox3(xk[47:40]);
    t4 = sbox4(xk[39:32]);
    t5 = sbox2(xk[31:24]);
    t6 = sbox3(xk[23:16]);
    t7 = sbox4(xk[15:8]);
    t8 = sbox1(xk[7:0]);
    y  = {t1 ^ t3 ^ t4 ^ t6 ^ t7 ^ t8,
          t1 ^ t2 ^ t4 ^ t5 ^ t7 ^ t8,
          t1 ^ t2 ^ t3 ^ t5 ^ t6 ^ t8,
          t2 ^ t3 ^ t4 ^ t5 ^ t6 ^ t7,
          t1 ^ t2 ^ t6 ^ t7 ^ t8,
          t2 ^ t3 ^ t5 ^ t7 ^ t8,
          t3 ^ t4 ^ t5 ^ t6 ^ t8,
          t1 ^ t4 ^ t5 ^ t6 ^ t7};
  end

endmodule

// File: rtl/camellia_ka_gen.sv
// Camellia-128 KA derivation from KL (four F rounds with a KL fold after round 1).
// Define CAM_KA_UNROLL_EN to run two rounds per cycle with two F instances.
module camellia_ka_gen (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] KL_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] KL,
  output logic [127:0] KA
);
  import camellia_pkg::*;

  ka_state_e    state_q, state_d;
  logic [1:0]   rnd_q, rnd_d;
  logic [63:0]  d1_q, d1_d, d2_q, d2_d;
  logic [127:0] klr_q, klr_d, kl_q, kl_d, ka_q, ka_d;
  logic         done_q, done_d;

`ifdef CAM_KA_UNROLL_EN
  logic [63:0] fa_k, fa_y, fb_k, fb_y, d2_mid;

  camellia_f u_f0 (.x(d1_q),   .k(fa_k), .y(fa_y));
  camellia_f u_f1 (.x(d2_mid), .k(fb_k), .y(fb_y));

  // rnd_q steps 0 -> 2: first cycle covers rounds 0/1, second covers rounds 2/3
  always_comb begin
    fa_k   = (rnd_q == 2'd0) ? SIGMA1 : SIGMA3;
    fb_k   = (rnd_q == 2'd0) ? SIGMA2 : SIGMA4;
    d2_mid = d2_q ^ fa_y;
  end
`else
  logic [63:0] f_x, f_k, f_y;

  camellia_f u_f (.x(f_x), .k(f_k), .y(f_y));

  always_comb begin
    f_x = rnd_q[0] ? d2_q : d1_q;
    case (rnd_q)
      2'd0:    f_k = SIGMA1;
      2'd1:    f_k = SIGMA2;
      2'd2:    f_k = SIGMA3;
      default: f_k = SIGMA4;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    klr_d   = klr_q;
    kl_d    = kl_q;
    ka_d    = ka_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          klr_d   = KL_in;
          d1_d    = KL_in[127:64];
          d2_d    = KL_in[63:0];
          rnd_d   = 2'd0;
          state_d = ST_RUN;
        end
      end
      default: begin
`ifdef CAM_KA_UNROLL_EN
        if (rnd_q == 2'd0) begin
          d1_d  = d1_q ^ fb_y ^ klr_q[127:64];
          d2_d  = d2_mid ^ klr_q[63:0];
          rnd_d = 2'd2;
        end else begin
          d1_d    = d1_q ^ fb_y;
          d2_d    = d2_mid;
          ka_d    = {d1_q ^ fb_y, d2_mid};
          kl_d    = klr_q;
          done_d  = 1'b1;
          rnd_d   = 2'd0;
          state_d = ST_IDLE;
        end
`else
        rnd_d = rnd_q + 2'd1;
        case (rnd_q)
          2'd0: d2_d = d2_q ^ f_y;
          2'd1: begin
            d1_d = d1_q ^ f_y ^ klr_q[127:64];
            d2_d = d2_q ^ klr_q[63:0];
          end
          2'd2: d2_d = d2_q ^ f_y;
          default: begin
            d1_d    = d1_q ^ f_y;
            ka_d    = {d1_q ^ f_y, d2_q};
            kl_d    = klr_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        endcase
`endif
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      klr_q   <= '0;
      kl_q    <= '0;
      ka_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      klr_q   <= klr_d;
      kl_q    <= kl_d;
      ka_q    <= ka_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign KL   = kl_q;
  assign KA   = ka_q;

endmodule

// File: tb/tb_camellia_ka_gen.sv
// Self-checking bench for camellia_ka_gen and camellia_f against a behavioural Camellia model.
module tb_camellia_ka_gen;

`ifdef CAM_KA_UNROLL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif

  localparam logic [63:0] SIG [4] = '{64'hA09E667F3BCC908B, 64'hB67AE8584CAA73B2,
                                      64'hC6EF372FE94F82BE, 64'h54FF53A5F1D36F1C};

  localparam int SB1 [256] = '{
    112,130, 44,236,179, 39,192,229,228,133, 87, 53,234, 12,174, 65,
     35,239,107,147, 69, 25,165, 33,237, 14, 79, 78, 29,101,146,189,
    134,184,175,143,124,235, 31,206, 62, 48,220, 95, 94,197, 11, 26,
    166,225, 57,202,213, 71, 93, 61,217,  1, 90,214, 81, 86,108, 77,
    139, 13,154,102,251,204,176, 45,116, 18, 43, 32,240,177,132,153,
    223, 76,203,194, 52,126,118,  5,109,183,169, 49,209, 23,  4,215,
     20, 88, 58, 97,222, 27, 17, 28, 50, 15,156, 22, 83, 24,242, 34,
    254, 68,207,178,195,181,122,145, 36,  8,232,168, 96,252,105, 80,
    170,208,160,125,161,137, 98,151, 84, 91, 30,149,224,255,100,210,
     16,196,  0, 72,163,247,117,219,138,  3,230,218,  9, 63,221,148,
    135, 92,131,  2,205, 74,144, 51,115,103,246,243,157,127,191,226,
     82,155,216, 38,200, 55,198, 59,129,150,111, 75, 19,190, 99, 46,
    233,121,167,140,159,110,188,142, 41,245,249,182, 47,253,180, 89,
    120,152,  6,106,231, 70,113,186,212, 37,171, 66,136,162,141,250,
    114,  7,185, 85,248,238,172, 10, 54, 73, 42,104, 60, 56,241,164,
     64, 40,211,123,187,201, 67,193, 21,227,173,244,119,199,128,158
  };

  // S-box choice per input byte, and which t bytes feed each output byte (MSB = t1)
  localparam int unsigned SEL [8] = '{1, 2, 3, 4, 2, 3, 4, 1};
  localparam logic [7:0]  PM  [8] = '{8'hB7, 8'hDB, 8'hED, 8'h7E, 8'hC7, 8'h6B, 8'h3D, 8'h9E};

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic [127:0] KL_in = '0;
  logic         busy, done;
  logic [127:0] KL, KA;
  logic [63:0]  fx = '0, fk = '0, fy;

  int checks = 0;
  int errors = 0;

  camellia_ka_gen dut (
    .CLK(CLK), .RST(RST), .start(start), .KL_in(KL_in),
    .busy(busy), .done(done), .KL(KL), .KA(KA)
  );

  camellia_f u_fchk (.x(fx), .k(fk), .y(fy));

  always #5 CLK = ~CLK;

  function automatic logic [7:0] m_sb(input int unsigned idx, input logic [7:0] b);
    logic [7:0] s, br;
    br = {b[6:0], b[7]};
    case (idx)
      1: s = 8'(SB1[b]);
      2: begin s = 8'(SB1[b]); s = {s[6:0], s[7]}; end
      3: begin s = 8'(SB1[b]); s = {s[0], s[7:1]}; end
      default: s = 8'(SB1[br]);
    endcase
    return s;
  endfunction

  function automatic logic [63:0] m_F(input logic [63:0] x, input logic [63:0] k);
    logic [63:0] v, r;
    logic [7:0]  t [8];
    logic [7:0]  o;
    v = x ^ k;
    for (int i = 0; i < 8; i++) t[i] = m_sb(SEL[i], v[63-8*i -: 8]);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      o = '0;
      for (int j = 0; j < 8; j++) if (PM[i][7-j]) o = o ^ t[j];
      r[63-8*i -: 8] = o;
    end
    return r;
  endfunction

  function automatic logic [127:0] m_ka(input logic [127:0] kl);
    logic [63:0] a, b;
    a = kl[127:64];
    b = kl[63:0];
    b = b ^ m_F(a, SIG[0]);
    a = a ^ m_F(b, SIG[1]);
    a = a ^ kl[127:64];
    b = b ^ kl[63:0];
    b = b ^ m_F(a, SIG[2]);
    a = a ^ m_F(b, SIG[3]);
    return {a, b};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (KL !== '0) begin errors++; $display("FAIL reset_KL got %h want 0", KL); end
    checks++; if (KA !== '0) begin errors++; $display("FAIL reset_KA got %h want 0", KA); end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_f_unit();
    logic [63:0] exp;
    fx = '0; fk = SIG[0]; #1;
    exp = m_F(64'h0, SIG[0]);
    checks++; if (fy !== exp) begin errors++; $display("FAIL f_zero got %h want %h", fy, exp); end
    for (int n = 0; n < 8; n++) begin
      int unsigned bitpos;
      bitpos = $urandom_range(63, 0);
      fx = '0; fx[bitpos] = 1'b1; #1;
      exp = m_F(fx, SIG[0]);
      checks++; if (fy !== exp) begin errors++; $display("FAIL f_flip%0d got %h want %h", bitpos, fy, exp); end
    end
    for (int n = 0; n < 4; n++) begin
      fx = {$urandom(), $urandom()}; fk = {$urandom(), $urandom()}; #1;
      exp = m_F(fx, fk);
      checks++; if (fy !== exp) begin errors++; $display("FAIL f_rand got %h want %h", fy, exp); end
    end
  endtask

  task automatic test_rfc_vector();
    logic [127:0] key;
    int cyc;
    key = 128'h0123456789ABCDEFFEDCBA9876543210;
    KL_in = key; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; KL_in = rand128();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rfc_busy got %b want 1", busy); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL rfc_latency got %0d want %0d", cyc, LAT); end
    checks++; if (KL !== key) begin errors++; $display("FAIL rfc_KL got %h want %h", KL, key); end
    checks++; if (KA !== m_ka(key)) begin errors++; $display("FAIL rfc_KA got %h want %h", KA, m_ka(key)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rfc_busy_done got %b want 0", busy); end
    @(posedge CLK); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rfc_done_pulse got %b want 0", done); end
    checks++; if (KA !== m_ka(key)) begin errors++; $display("FAIL rfc_KA_hold got %h want %h", KA, m_ka(key)); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] keys [30];
    int hi, cyc;
    for (int i = 0; i < 30; i++) keys[i] = rand128();
    KL_in = keys[0]; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      hi = 0; cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
        if (busy === 1'b1) hi++;
        @(posedge CLK); #1; cyc++;
      end
      checks++; if (cyc !== LAT) begin errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, cyc, LAT); end
      checks++; if (hi !== LAT) begin errors++; $display("FAIL b2b_busy_hi[%0d] got %0d want %0d", i, hi, LAT); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_lo[%0d] got %b want 0", i, busy); end
      checks++; if (KA !== m_ka(keys[i])) begin errors++; $display("FAIL b2b_KA[%0d] got %h want %h", i, KA, m_ka(keys[i])); end
      checks++; if (KL !== keys[i]) begin errors++; $display("FAIL b2b_KL[%0d] got %h want %h", i, KL, keys[i]); end
      if (i < 29) begin
        KL_in = keys[i+1]; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_clr[%0d] got %b want 0", i, done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart[%0d] got %b want 1", i, busy); end
      end
    end
  endtask

  task automatic test_start_held();
    logic [127:0] cur;
    int ndone, n;
    n = 3 * (LAT + 1);
    KL_in = rand128(); cur = KL_in; start = 1'b1;
    ndone = 0;
    for (int it = 0; it < n; it++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) begin
        ndone++;
        checks++; if (KA !== m_ka(cur)) begin errors++; $display("FAIL held_KA got %h want %h", KA, m_ka(cur)); end
        checks++; if (KL !== cur) begin errors++; $display("FAIL held_KL got %h want %h", KL, cur); end
      end
      KL_in = rand128();
      if (it == n - 1) start = 1'b0;
      else if (busy !== 1'b1) cur = KL_in;
    end
    for (int it = 0; it < LAT + 2; it++) begin
      @(posedge CLK); #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone !== 3) begin errors++; $display("FAIL held_done_count got %0d want 3", ndone); end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] key;
    int nd, cyc;
    KL_in = rand128(); start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (KL !== '0) begin errors++; $display("FAIL rst_KL got %h want 0", KL); end
    checks++; if (KA !== '0) begin errors++; $display("FAIL rst_KA got %h want 0", KA); end
    repeat (2) @(posedge CLK);
    #1; RST = 1'b1;
    nd = 0;
    for (int it = 0; it < LAT + 3; it++) begin
      @(posedge CLK); #1;
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rst_no_done got %0d want 0", nd); end
    key = rand128();
    KL_in = key; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL rst_relatency got %0d want %0d", cyc, LAT); end
    checks++; if (KA !== m_ka(key)) begin errors++; $display("FAIL rst_KA_new got %h want %h", KA, m_ka(key)); end
  endtask

  task automatic test_zero_key();
    int cyc;
    @(posedge CLK); #1;
    KL_in = '0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin @(posedge CLK); #1; cyc++; end
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL zero_latency got %0d want %0d", cyc, LAT); end
    checks++; if (KA !== m_ka(128'h0)) begin errors++; $display("FAIL zero_KA got %h want %h", KA, m_ka(128'h0)); end
    checks++; if (KL !== '0) begin errors++; $display("FAIL zero_KL got %h want 0", KL); end
  endtask

  initial begin
    test_reset();
    test_f_unit();
    test_rfc_vector();
    test_back_to_back();
    test_start_held();
    test_reset_mid_run();
    test_zero_key();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
